// File: rtl/usb_rnd_src.sv
// Pseudo-random 5-bit word source for the USB noise generator: 31-bit Fibonacci LFSR
// (x^31+x^28+1) with seed load, all-zero lockup recovery and a repetition health check.
// Define RND_NOISE_MIX_EN to synchronise noise_in and XOR it into the LFSR feedback.
module usb_rnd_src #(
  parameter logic [30:0] SEED      = 31'h1ACE_B00C,
  parameter int unsigned REP_LIMIT = 7
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        noise_in,
  input  logic        seed_load,
  input  logic [30:0] seed_val,
  output logic [4:0]  rnd,
  output logic        rnd_stb,
  output logic        stuck,
  output logic        lockup
);

  logic [30:0] lfsr_q, lfsr_d;
  logic [3:0]  col_q, col_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        rnd_stb_q, rnd_stb_d;
  logic [3:0]  rep_cnt_q, rep_cnt_d;
  logic        stuck_q, stuck_d;
  logic        lockup_q, lockup_d;
  logic        noise_s;
  logic        fb;

`ifdef RND_NOISE_MIX_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], noise_in};
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign noise_s = sync_q[1];
`else
  logic unused_noise_in;
  assign unused_noise_in = noise_in;
  assign noise_s         = 1'b0;
`endif

  assign fb = lfsr_q[30] ^ lfsr_q[27] ^ noise_s;

  always_comb begin
    lfsr_d    = lfsr_q;
    col_d     = col_q;
    bit_cnt_d = bit_cnt_q;
    rnd_d     = rnd_q;
    rnd_stb_d = 1'b0;
    rep_cnt_d = rep_cnt_q;
    stuck_d   = stuck_q;
    lockup_d  = 1'b0;

    if (seed_load) begin
      lfsr_d    = (seed_val == 31'd0) ? SEED : seed_val;
      col_d     = 4'd0;
      bit_cnt_d = 3'd0;
      rep_cnt_d = 4'd0;
      stuck_d   = 1'b0;
    end else if (lfsr_q == 31'd0) begin
      // Recovery leaves the partially collected word intact.
      lfsr_d   = SEED;
      lockup_d = 1'b1;
    end else begin
      lfsr_d = {lfsr_q[29:0], fb};
      if (bit_cnt_q == 3'd4) begin
        rnd_d     = {col_q, fb};
        rnd_stb_d = 1'b1;
        bit_cnt_d = 3'd0;
        if (rnd_d == rnd_q) begin
          if (rep_cnt_q != 4'hF) begin
            rep_cnt_d = rep_cnt_q + 4'd1;
          end
        end else begin
          rep_cnt_d = 4'd0;
        end
        if (rep_cnt_d >= 4'(REP_LIMIT)) begin
          stuck_d = 1'b1;
        end
      end else begin
        col_d     = {col_q[2:0], fb};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      lfsr_q    <= SEED;
      col_q     <= 4'd0;
      bit_cnt_q <= 3'd0;
      rnd_q     <= 5'd0;
      rnd_stb_q <= 1'b0;
      rep_cnt_q <= 4'd0;
      stuck_q   <= 1'b0;
      lockup_q  <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      col_q     <= col_d;
      bit_cnt_q <= bit_cnt_d;
      rnd_q     <= rnd_d;
      rnd_stb_q <= rnd_stb_d;
      rep_cnt_q <= rep_cnt_d;
      stuck_q   <= stuck_d;
      lockup_q  <= lockup_d;
    end
  end

  assign rnd     = rnd_q;
  assign rnd_stb = rnd_stb_q;
  assign stuck   = stuck_q;
  assign lockup  = lockup_q;

endmodule

// File: tb/tb_usb_rnd_src.sv
// Scoreboard bench for usb_rnd_src: two instances (REP_LIMIT 7 and 4) with SEED=1.
// Expected words for SEED=1 are hand-derived from the feedback stream.
module tb_usb_rnd_src;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  rnd;
    logic        stuck;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rst_a, rst_b;
  logic        noise_a, noise_b;
  logic        load_a, load_b;
  logic [30:0] sval_a, sval_b;
  logic [4:0]  rnd_a, rnd_b;
  logic        stb_a, stb_b, stuck_a, stuck_b, lock_a, lock_b;
  logic        mon_en_a = 1'b1;
  logic        mon_en_b = 1'b1;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [4:0]  wexp[13];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_rnd_src #(.SEED(31'h1), .REP_LIMIT(7)) dut_a (
    .clk_in(clk), .reset(rst_a), .noise_in(noise_a), .seed_load(load_a), .seed_val(sval_a),
    .rnd(rnd_a), .rnd_stb(stb_a), .stuck(stuck_a), .lockup(lock_a)
  );

  usb_rnd_src #(.SEED(31'h1), .REP_LIMIT(4)) dut_b (
    .clk_in(clk), .reset(rst_b), .noise_in(noise_b), .seed_load(load_b), .seed_val(sval_b),
    .rnd(rnd_b), .rnd_stb(stb_b), .stuck(stuck_b), .lockup(lock_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitors: pop on every strobe and compare word, health flag and arrival cycle.
  always @(negedge clk) begin
    if (mon_en_a && stb_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_stb", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_stb_cycle", cyc, e.cyc);
        chk("a_rnd", {27'd0, rnd_a}, {27'd0, e.rnd});
        chk("a_stuck", {31'd0, stuck_a}, {31'd0, e.stuck});
        chk("a_lockup", {31'd0, lock_a}, 32'd0);
      end
    end
    if (mon_en_b && stb_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_stb", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_stb_cycle", cyc, e.cyc);
        chk("b_rnd", {27'd0, rnd_b}, {27'd0, e.rnd});
        chk("b_stuck", {31'd0, stuck_b}, {31'd0, e.stuck});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    for (int i = 0; i < 13; i++) wexp[i] = 5'b00000;
    wexp[5]  = 5'b00100;
    wexp[6]  = 5'b10000;
    wexp[11] = 5'b10000;
    wexp[12] = 5'b01000;

    rst_a = 1'b1; rst_b = 1'b1;
    noise_a = 1'b0; noise_b = 1'b0;
    load_a = 1'b0; load_b = 1'b0;
    sval_a = 31'd0; sval_b = 31'd0;
    repeat (3) @(negedge clk);

    chk("rst_rnd_a", {27'd0, rnd_a}, 32'd0);
    chk("rst_stb_a", {31'd0, stb_a}, 32'd0);
    chk("rst_stuck_a", {31'd0, stuck_a}, 32'd0);
    chk("rst_lockup_a", {31'd0, lock_a}, 32'd0);
    chk("rst_rnd_b", {27'd0, rnd_b}, 32'd0);
    chk("rst_stb_b", {31'd0, stb_b}, 32'd0);
    chk("rst_stuck_b", {31'd0, stuck_b}, 32'd0);

    // Release reset: word n arrives 5*(n+1) edges later.
    c = cyc;
    for (int n = 0; n < 13; n++) begin
      qa.push_back('{cyc: 32'(c + 5 + 5 * n), rnd: wexp[n], stuck: 1'b0});
      qb.push_back('{cyc: 32'(c + 5 + 5 * n), rnd: wexp[n], stuck: (n >= 3)});
    end
    rst_a = 1'b0; rst_b = 1'b0;

    // Seed loads land two edges after the 13th word; the pending 14th is discarded.
    wait_cyc(c + 67);
    load_a = 1'b1; sval_a = 31'd0;
    load_b = 1'b1; sval_b = 31'h5A5A_5A5A;
    for (int n = 0; n < 13; n++)
      qa.push_back('{cyc: 32'(c + 73 + 5 * n), rnd: wexp[n], stuck: 1'b0});
    qb.push_back('{cyc: 32'(c + 73), rnd: 5'b00010, stuck: 1'b0});
    qb.push_back('{cyc: 32'(c + 78), rnd: 5'b00100, stuck: 1'b0});
    wait_cyc(c + 68);
    load_a = 1'b0; load_b = 1'b0;
    chk("load_hold_rnd_a", {27'd0, rnd_a}, {27'd0, wexp[12]});
    chk("load_no_stb_a", {31'd0, stb_a}, 32'd0);
    chk("load_hold_rnd_b", {27'd0, rnd_b}, {27'd0, wexp[12]});
    chk("load_no_stb_b", {31'd0, stb_b}, 32'd0);
    chk("load_clr_stuck_b", {31'd0, stuck_b}, 32'd0);

    // Reset B when three bits of the next word are collected.
    wait_cyc(c + 81);
    rst_b = 1'b1;
    wait_cyc(c + 82);
    rst_b = 1'b0;
    chk("midword_rst_rnd_b", {27'd0, rnd_b}, 32'd0);
    chk("midword_rst_stb_b", {31'd0, stb_b}, 32'd0);
    chk("midword_rst_stuck_b", {31'd0, stuck_b}, 32'd0);
    for (int n = 0; n < 10; n++)
      qb.push_back('{cyc: 32'(c + 87 + 5 * n), rnd: wexp[n], stuck: (n >= 3)});

    wait_cyc(c + 136);
    mon_en_a = 1'b0; mon_en_b = 1'b0;
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

`ifdef RND_NOISE_MIX_EN
    noise_a = 1'b1;
    repeat (3) @(negedge clk);
    load_a = 1'b1; sval_a = 31'h4000_0000;
    @(negedge clk);
    load_a = 1'b0;
    chk("mix_loaded", {1'b0, dut_a.lfsr_q}, 32'h4000_0000);
    @(negedge clk);
    chk("mix_lfsr_zero", {1'b0, dut_a.lfsr_q}, 32'd0);
    chk("mix_no_lockup_yet", {31'd0, lock_a}, 32'd0);
    @(negedge clk);
    chk("mix_lockup_pulse", {31'd0, lock_a}, 32'd1);
    chk("mix_lfsr_seed", {1'b0, dut_a.lfsr_q}, 32'd1);
    @(negedge clk);
    chk("mix_lockup_single", {31'd0, lock_a}, 32'd0);
    noise_a = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rnd_src.md
# usb_rnd_src

Pseudo-random source for the USB noise generator: a 31-bit LFSR, optionally whitened by an external analog noise pin, packed into 5-bit words on the `rnd` bus consumed by the packet-storm shouter. Every 5 clocks it updates `rnd` and pulses `rnd_stb`. It also provides seed loading, all-zero lockup recovery and a repetition health check. It sits directly upstream of the shouter and runs in the same `clk_in` domain.

## Interface
- `SEED`, 31'h1ACE_B00C, LFSR value after reset and after lockup recovery; must be non-zero.
- `REP_LIMIT`, 7, number of consecutive equal `rnd` updates that sets `stuck`; range 1..15.
- `clk_in`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `noise_in`  in  1  asynchronous external noise bit; 2-FF synchronised internally.
- `seed_load`  in  1  one-cycle request to load `seed_val`.
- `seed_val`  in  31  seed value; zero is replaced by `SEED`.
- `rnd`  out  5  random word to the shouter; held between updates.
- `rnd_stb`  out  1  one-cycle pulse in the cycle `rnd` takes a new value.
- `stuck`  out  1  sticky health failure flag.
- `lockup`  out  1  one-cycle pulse when all-zero LFSR recovery fires.

## Operation
- LFSR is Fibonacci, x^31+x^28+1. Each clock: `lfsr <= {lfsr[29:0], fb}`, with `fb = lfsr[30] ^ lfsr[27] (^ noise_s when mixing is compiled in)`.
- Collector `col[3:0]` and counter `bit_cnt` (0..4) capture `fb` every clock. While `bit_cnt` is 0..3: `col <= {col[2:0], fb}` and `bit_cnt` increments. At `bit_cnt` == 4: `rnd <= {col, fb}` (first-collected bit is the MSB), `rnd_stb <= 1`, `bit_cnt <= 0`.
- Repetition check on each update: `rep_cnt` (4 bits) increments if the new `rnd` equals the current `rnd`, otherwise it clears to 0. When `rep_cnt` reaches `REP_LIMIT`, `stuck <= 1`. `stuck` stays set until `reset` or `seed_load`.
- Lockup: if `lfsr` == 0 in any non-reset, non-load cycle, then next cycle `lfsr <= SEED`, `lockup <= 1` for one clock, and `bit_cnt`/`col` are not disturbed.
- Seed load: `lfsr <= (seed_val == 0) ? SEED : seed_val`, then `bit_cnt <= 0`, `col <= 0`, `rep_cnt <= 0`, `stuck <= 0`. `rnd` holds its value and there is no `rnd_stb` in that cycle.
- Priority: `reset` > `seed_load` > lockup recovery > normal shift.
- `rnd_stb` is informational only. The consumer may sample `rnd` on any cycle, and `rnd` never glitches mid-word.

## Timing
- Reset values: `lfsr` = `SEED`, `rnd` = 0, `rnd_stb` = 0, `stuck` = 0, `lockup` = 0, `bit_cnt` = 0, `col` = 0, `rep_cnt` = 0, noise synchroniser = 0.
- First `rnd_stb` is high in the 5th clock after `reset` is sampled low, then every 5 clocks.
- After a `seed_load` cycle, the next `rnd_stb` is high in the 5th following clock.
- `noise_in` reaches `fb` 2 clocks after it is sampled; this latency applies only with mixing compiled in.
- `stuck` rises in the same clock as the `rnd_stb` of the update that hits `REP_LIMIT`.
- `lockup` is high the clock after `lfsr` == 0; `lfsr` == `SEED` in that same clock.
- `reset` mid-word discards the collector and gives no partial update.

## Configuration
- `RND_NOISE_MIX_EN` defined: the 2-FF synchroniser is built and `noise_s` is XORed into `fb`. Lockup becomes reachable, so recovery is exercised.
- `RND_NOISE_MIX_EN` undefined: `noise_in` is ignored and no synchroniser is instantiated. Output is a pure, deterministic LFSR sequence. Lockup logic remains but cannot fire from a non-zero state.

## Test plan
- Build without mix, `SEED`=31'h1, `REP_LIMIT`=7, reset, run 30 clocks:
  - the first five `rnd_stb` updates give `rnd` = 0, and the 6th gives `rnd` = 5'b00100;
  - `rnd_stb` period is exactly 5;
  - `stuck` stays 0.
- Same build with `REP_LIMIT`=4: `stuck` rises with the 4th `rnd_stb` and stays high. Then pulse `seed_load` with `seed_val`=31'h5A5A_5A5A: `stuck` clears next clock and the next `rnd_stb` comes 5 clocks later.
- Pulse `seed_load` with `seed_val`=0: the LFSR equals `SEED` next clock, and the output sequence is identical to the post-reset sequence.
- Build with mix: hold `noise_in`=1 for 3 clocks, then `seed_load` with `seed_val`=31'h4000_0000:
  - the next clock `lfsr` = 0;
  - the clock after, `lockup` = 1 for exactly one clock and `lfsr` = `SEED`.
- Mix build: toggle `noise_in` randomly and compare against a no-mix run with the same `SEED`. The `rnd` sequences diverge no earlier than 2 clocks after the first `noise_in`=1.
- Assert `reset` while `bit_cnt`=3: `rnd` = 0 and `rnd_stb` = 0 next clock, and the first update comes 5 clocks after release.
